// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial, LSB-first unsigned subtractor: diff = a - b (mod 2^WIDTH).
//   Computed as a + ~b + 1 through a single full-adder cell. The carry
//   register starts at 1, which supplies the "+1".
//   One bit is produced per clock.
//
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous, active-high reset
//     start       load a/b and begin; accepted only in IDLE or DONE
//     a, b        minuend / subtrahend, sampled when start is accepted
//     busy        high for the WIDTH cycles of the shift phase
//     done        one-cycle pulse when diff/borrow_out carry a new result
//     diff        a - b mod 2^WIDTH, held until the next result
//     borrow_out  1 when a < b (unsigned), held with diff
// ---------------------------------------------------------------------------

// Single-bit full adder used as the serial arithmetic cell.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;

   logic [WIDTH-1:0] a_sr_reg;
   logic [WIDTH-1:0] b_sr_reg;
   logic [WIDTH-1:0] res_sr_reg;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             borrow_reg;

   logic             load;
   logic             shift;
   logic             finish;
   logic             fa_sum;
   logic             fa_cout;

   // Subtraction: a + ~b + carry, carry seeded with 1 on load.
   fulladder u_fa (
      .a    (a_sr_reg[0]),
      .b    (~b_sr_reg[0]),
      .cin  (carry_reg),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state and datapath control
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      shift      = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // start is deliberately ignored while shifting
            shift = 1'b1;
            if (cnt_reg == CW'(WIDTH - 1))
               state_next = DONE;
         end
         DONE: begin
            finish = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath. In DONE with start high, finish reads the old res_sr/carry
   // while load reinitialises them, so back-to-back operations do not clash.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         res_sr_reg <= '0;
         cnt_reg    <= '0;
         carry_reg  <= 1'b1;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
      end else begin
         if (load) begin
            a_sr_reg   <= a;
            b_sr_reg   <= b;
            res_sr_reg <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b1;
         end else if (shift) begin
            a_sr_reg   <= a_sr_reg >> 1;
            b_sr_reg   <= b_sr_reg >> 1;
            res_sr_reg <= {fa_sum, res_sr_reg[WIDTH-1:1]};
            carry_reg  <= fa_cout;
            cnt_reg    <= cnt_reg + CW'(1);
         end

         if (finish) begin
            diff_reg   <= res_sr_reg;
            // A final carry of 0 means a + ~b + 1 did not overflow: a < b.
            borrow_reg <= ~carry_reg;
         end

         // Flags are registered alongside diff, so done coincides with the
         // new result and never overlaps busy, even back-to-back.
         busy_reg <= (state_reg == SHIFT);
         done_reg <= (state_reg == DONE);
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign diff       = diff_reg;
   assign borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Result the DUT should currently be holding.
   logic [W-1:0] held_diff;
   logic         held_borrow;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus only: one-cycle start pulse, then scramble operands so any
   // late sampling of a/b would corrupt the result. Returns at the falling
   // edge just after the accepting rising edge.
   task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(negedge clk);
      n_checks++;
      if ({busy, done, borrow_out, diff} !== '0)
         $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, required all 0",
                  busy, done, diff, borrow_out);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0 || diff !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b diff=%h, required 0 0 00", busy, done, diff);
         end
      end
      held_diff   = '0;
      held_borrow = 1'b0;
      $display("reset: outputs idle at zero");
   endtask

   // Directed boundary cases followed by random operands.
   task automatic test_arith(input int n_rand);
      logic [W-1:0] ta [7] = '{8'd5, 8'd3, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h00};
      logic [W-1:0] tb_[7] = '{8'd3, 8'd5, 8'h01, 8'hFF, 8'h00, 8'h7F, 8'hFF};
      logic [W-1:0] av, bv, nd, ed;
      logic         nb, eb;
      for (int i = 0; i < 7 + n_rand; i++) begin
         if (i < 7) begin
            av = ta[i];
            bv = tb_[i];
         end else begin
            av = W'($urandom);
            bv = W'($urandom);
         end
         nd = av - bv;
         nb = (av < bv);
         pulse_start(av, bv);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL arith_accept: busy=%b done=%b, required 0 0", busy, done);
         end
         for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'(k <= 8) || done !== 1'(k == 9)) begin
               n_fail++;
               $display("FAIL arith_timing k=%0d: busy=%b done=%b, required %b %b",
                        k, busy, done, 1'(k <= 8), 1'(k == 9));
            end
            ed = (k >= 9) ? nd : held_diff;
            eb = (k >= 9) ? nb : held_borrow;
            n_checks++;
            if (diff !== ed || borrow_out !== eb) begin
               n_fail++;
               $display("FAIL arith_result k=%0d a=%h b=%h: diff=%h borrow=%b, required %h %b",
                        k, av, bv, diff, borrow_out, ed, eb);
            end
         end
         held_diff   = nd;
         held_borrow = nb;
         $display("op: a=%h b=%h -> diff=%h borrow=%b (expected %h %b)", av, bv, diff, borrow_out, nd, nb);
      end
   endtask

   task automatic test_start_ignored;
      logic [W-1:0] ed;
      logic         eb;
      pulse_start(8'h20, 8'h01);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'(k <= 8) || done !== 1'(k == 9)) begin
            n_fail++;
            $display("FAIL ignore_timing k=%0d: busy=%b done=%b, required %b %b",
                     k, busy, done, 1'(k <= 8), 1'(k == 9));
         end
         ed = (k >= 9) ? 8'h1F : held_diff;
         eb = (k >= 9) ? 1'b0 : held_borrow;
         n_checks++;
         if (diff !== ed || borrow_out !== eb) begin
            n_fail++;
            $display("FAIL ignore_result k=%0d: diff=%h borrow=%b, required %h %b", k, diff, borrow_out, ed, eb);
         end
         if (k == 3) begin
            start = 1'b1;
            a     = 8'd9;
            b     = 8'd9;
         end
         if (k == 4) start = 1'b0;
      end
      held_diff   = 8'h1F;
      held_borrow = 1'b0;
      $display("op: a=20 b=01 with mid-shift restart -> diff=%h borrow=%b", diff, borrow_out);
   endtask

   task automatic test_reset_mid_shift;
      logic [W-1:0] ed;
      pulse_start(8'h5A, 8'h13);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, borrow_out, diff} !== '0) begin
         n_fail++;
         $display("FAIL midreset_clear: busy=%b done=%b diff=%h borrow=%b, required all 0",
                  busy, done, diff, borrow_out);
      end
      held_diff   = '0;
      held_borrow = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0 || diff !== '0) begin
            n_fail++;
            $display("FAIL midreset_quiet k=%0d: busy=%b done=%b diff=%h, required 0 0 00", k, busy, done, diff);
         end
      end
      pulse_start(8'd7, 8'd2);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'(k <= 8) || done !== 1'(k == 9)) begin
            n_fail++;
            $display("FAIL midreset_timing k=%0d: busy=%b done=%b, required %b %b",
                     k, busy, done, 1'(k <= 8), 1'(k == 9));
         end
         ed = (k >= 9) ? 8'h05 : 8'h00;
         n_checks++;
         if (diff !== ed || borrow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_result k=%0d: diff=%h borrow=%b, required %h 0", k, diff, borrow_out, ed);
         end
      end
      held_diff   = 8'h05;
      held_borrow = 1'b0;
      $display("op: reset mid-shift then a=07 b=02 -> diff=%h borrow=%b", diff, borrow_out);
   endtask

   task automatic test_back_to_back;
      logic         eb_busy, eb_done, eb;
      logic [W-1:0] ed;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h30;
      b     = 8'h05;
      @(negedge clk);
      a = 8'h10;
      b = 8'h20;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         eb_busy = ((k >= 1 && k <= 8) || (k >= 10 && k <= 17));
         eb_done = (k == 9 || k == 18);
         n_checks++;
         if (busy !== eb_busy || done !== eb_done) begin
            n_fail++;
            $display("FAIL b2b_timing k=%0d: busy=%b done=%b, required %b %b", k, busy, done, eb_busy, eb_done);
         end
         if (k < 9) begin
            ed = held_diff;
            eb = held_borrow;
         end else if (k < 18) begin
            ed = 8'h2B;
            eb = 1'b0;
         end else begin
            ed = 8'hF0;
            eb = 1'b1;
         end
         n_checks++;
         if (diff !== ed || borrow_out !== eb) begin
            n_fail++;
            $display("FAIL b2b_result k=%0d: diff=%h borrow=%b, required %h %b", k, diff, borrow_out, ed, eb);
         end
         if (k == 9) begin
            $display("op: a=30 b=05 -> diff=%h borrow=%b (expected 2b 0)", diff, borrow_out);
            start = 1'b0;
         end
      end
      held_diff   = 8'hF0;
      held_borrow = 1'b1;
      $display("op: back-to-back a=10 b=20 -> diff=%h borrow=%b (expected f0 1)", diff, borrow_out);
   endtask

   initial begin
      test_reset();
      test_arith(24);
      test_start_ignored();
      test_reset_mid_shift();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

●
